// File: rtl/reg_context_seq_pkg.sv
// Shared types for the LC-3 register context save/restore sequencer.
package SLC3_2;

  localparam int CTX_NREGS = 8;

  typedef enum logic [2:0] {
    IDLE,
    SV_RD,
    SV_MEM,
    RS_MEM,
    RS_LD,
    FIN,
    ABORT
  } ctx_state_t;

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int ctx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_context_seq_ack_timer.sv
// Counts cycles spent waiting for a memory acknowledge; flags expiry at the limit.
module ack_timer #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_inc;

  assign cnt_inc = cnt_reg + W'(1);

  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_inc;
    end
  end

  // Fires in the cycle whose increment would make the count equal the limit; limit 0 never fires.
  assign expired = en && (limit != '0) && (cnt_inc == limit);

endmodule

// File: rtl/reg_context_seq.sv
// Saves the LC-3 general registers to memory or restores them, acting as
// register-file initiator on one side and req/ack memory master on the other.
module reg_context_seq
  import SLC3_2::*;
#(
  parameter int NREGS       = CTX_NREGS,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Save,
  input  logic        Restore,
  input  logic [15:0] Base,
  output logic [2:0]  SR1_SEL,
  input  logic [15:0] SR1_DATA,
  output logic [2:0]  DR_SEL,
  output logic [15:0] REG_WDATA,
  output logic        LD_REG_OUT,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  input  logic [15:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  localparam int IDX_W = ctx_width(NREGS);
  localparam int TMR_W = ctx_width(ACK_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  ctx_state_t       state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [15:0]      hold_reg, hold_next;
  logic [15:0]      base_reg, base_next;

  logic        mem_req_comb;
  logic        ld_reg_comb;
  logic        in_mem;
  logic        timer_expired;
  logic [15:0] addr_calc;

  assign in_mem    = (state_reg == SV_MEM) || (state_reg == RS_MEM);
  assign addr_calc = base_reg + 16'(idx_reg);

  ack_timer #(.W(TMR_W)) u_ack_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .clr     (!in_mem),
    .en      (in_mem && !MEM_ACK),
    .limit   (TMR_W'(ACK_TIMEOUT)),
    .expired (timer_expired)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      hold_reg  <= '0;
      base_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      hold_reg  <= hold_next;
      base_reg  <= base_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    hold_next    = hold_reg;
    base_next    = base_reg;
    SR1_SEL      = '0;
    DR_SEL       = '0;
    REG_WDATA    = '0;
    ld_reg_comb  = 1'b0;
    mem_req_comb = 1'b0;
    MEM_WE       = 1'b0;
    MEM_ADDR     = '0;
    MEM_WDATA    = '0;
    Busy         = (state_reg != IDLE);
    Done         = 1'b0;
    Error        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (Save) begin
          base_next  = Base;
          idx_next   = '0;
          state_next = SV_RD;
        end else if (Restore) begin
          base_next  = Base;
          idx_next   = '0;
          state_next = RS_MEM;
        end
      end
      SV_RD: begin
        SR1_SEL    = 3'(idx_reg);
        hold_next  = SR1_DATA;
        state_next = SV_MEM;
      end
      SV_MEM: begin
        mem_req_comb = 1'b1;
        MEM_WE       = 1'b1;
        MEM_ADDR     = addr_calc;
        MEM_WDATA    = hold_reg;
        if (MEM_ACK) begin
          if (idx_reg == LAST_IDX) begin
            state_next = FIN;
          end else begin
            idx_next   = idx_reg + IDX_W'(1);
            state_next = SV_RD;
          end
        end else if (timer_expired) begin
          state_next = ABORT;
        end
      end
      RS_MEM: begin
        mem_req_comb = 1'b1;
        MEM_ADDR     = addr_calc;
        if (MEM_ACK) begin
          hold_next  = MEM_RDATA;
          state_next = RS_LD;
        end else if (timer_expired) begin
          state_next = ABORT;
        end
      end
      RS_LD: begin
        DR_SEL      = 3'(idx_reg);
        REG_WDATA   = hold_reg;
        ld_reg_comb = 1'b1;
        if (idx_reg == LAST_IDX) begin
          state_next = FIN;
        end else begin
          idx_next   = idx_reg + IDX_W'(1);
          state_next = RS_MEM;
        end
      end
      FIN: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      ABORT: begin
        Error      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The register file honours LD_REG over its own reset, so strobes must drop within the reset cycle.
  assign LD_REG_OUT = ld_reg_comb & ~Reset;
  assign MEM_REQ    = mem_req_comb & ~Reset;

endmodule

// File: tb/tb_reg_context_seq.sv
// Scoreboard bench for reg_context_seq with a behavioural register file and memory.
module tb_reg_context_seq;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Save;
  logic        Restore;
  logic [15:0] Base;
  logic [2:0]  SR1_SEL;
  logic [15:0] SR1_DATA;
  logic [2:0]  DR_SEL;
  logic [15:0] REG_WDATA;
  logic        LD_REG_OUT;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [15:0] MEM_ADDR;
  logic [15:0] MEM_WDATA;
  logic [15:0] MEM_RDATA = 16'h0000;
  logic        MEM_ACK = 1'b0;
  logic        Busy;
  logic        Done;
  logic        Error;

  reg_context_seq #(.NREGS(8), .ACK_TIMEOUT(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Save       (Save),
    .Restore    (Restore),
    .Base       (Base),
    .SR1_SEL    (SR1_SEL),
    .SR1_DATA   (SR1_DATA),
    .DR_SEL     (DR_SEL),
    .REG_WDATA  (REG_WDATA),
    .LD_REG_OUT (LD_REG_OUT),
    .MEM_REQ    (MEM_REQ),
    .MEM_WE     (MEM_WE),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_WDATA  (MEM_WDATA),
    .MEM_RDATA  (MEM_RDATA),
    .MEM_ACK    (MEM_ACK),
    .Busy       (Busy),
    .Done       (Done),
    .Error      (Error)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } xfer_t;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [15:0] mem  [0:65535];
  logic [15:0] regs [0:7];
  xfer_t exp_q[$];
  xfer_t wr_q[$];
  xfer_t ld_exp_q[$];
  xfer_t ld_q[$];

  int          ack_delay     = 0;
  int          wait_cnt      = 0;
  int          rd_req_cycles = 0;
  logic        hang_en       = 1'b0;
  logic [15:0] hang_addr     = 16'h0000;

  int first_busy, last_busy, busy_n, done_cyc, done_n, err_cyc, err_n;

  assign SR1_DATA = regs[SR1_SEL];

  // Register file: write on LD_REG at the clock edge, log each load.
  always @(posedge Clk) begin
    if (LD_REG_OUT) begin
      regs[DR_SEL] <= REG_WDATA;
      ld_q.push_back({13'd0, DR_SEL, REG_WDATA});
    end
  end

  // Memory: ACK after ack_delay wait cycles, never for hang_addr when enabled.
  always @(negedge Clk) begin
    if (MEM_REQ) begin
      if (!MEM_WE) rd_req_cycles++;
      if ((!hang_en || MEM_ADDR != hang_addr) && wait_cnt >= ack_delay) begin
        MEM_ACK   = 1'b1;
        MEM_RDATA = mem[MEM_ADDR];
        if (MEM_WE) begin
          mem[MEM_ADDR] = MEM_WDATA;
          wr_q.push_back({MEM_ADDR, MEM_WDATA});
        end
        wait_cnt = 0;
      end else begin
        MEM_ACK   = 1'b0;
        MEM_RDATA = 16'h0000;
        wait_cnt++;
      end
    end else begin
      MEM_ACK   = 1'b0;
      MEM_RDATA = 16'h0000;
      wait_cnt  = 0;
    end
  end

  task automatic start_op(input logic s, input logic r, input logic [15:0] b);
    @(negedge Clk);
    Save = s; Restore = r; Base = b;
    @(negedge Clk);
    Save = 1'b0; Restore = 1'b0; Base = 16'hDEAD;
  endtask

  // Cycle 1 is the first cycle after the start was sampled.
  task automatic run_watch(input int budget);
    first_busy = -1; last_busy = -1; busy_n = 0;
    done_cyc = -1; done_n = 0; err_cyc = -1; err_n = 0;
    for (int c = 1; c <= budget; c++) begin
      if (Busy) begin
        if (first_busy < 0) first_busy = c;
        last_busy = c;
        busy_n++;
      end
      if (Done) begin
        if (done_cyc < 0) done_cyc = c;
        done_n++;
      end
      if (Error) begin
        if (err_cyc < 0) err_cyc = c;
        err_n++;
      end
      @(negedge Clk);
    end
  endtask

  task automatic clear_logs();
    exp_q.delete(); wr_q.delete(); ld_exp_q.delete(); ld_q.delete();
    rd_req_cycles = 0;
  endtask

  task automatic test_reset();
    logic [59:0] outs;
    Reset = 1'b1; Save = 1'b0; Restore = 1'b0; Base = 16'h0000;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    outs = {Busy, Done, Error, MEM_REQ, MEM_WE, LD_REG_OUT, SR1_SEL, DR_SEL,
            REG_WDATA, MEM_ADDR, MEM_WDATA};
    chk_cnt++;
    if (outs !== 60'd0) $display("FAIL reset_outputs actual=%h required=0", outs);
    else pass_cnt++;
    $display("txn reset outputs=%h", outs);
  endtask

  task automatic test_save_basic();
    xfer_t e, o;
    clear_logs();
    ack_delay = 0;
    for (int i = 0; i < 8; i++) begin
      regs[i] <= 16'h1110 + 16'(i);
      exp_q.push_back({16'h3000 + 16'(i), 16'h1110 + 16'(i)});
    end
    start_op(1'b1, 1'b0, 16'h3000);
    run_watch(30);
    $display("txn save base=3000 done_cyc=%0d busy=%0d..%0d writes=%0d", done_cyc, first_busy, last_busy, wr_q.size());
    chk_cnt++;
    if (done_cyc !== 17) $display("FAIL save_done_cycle actual=%0d required=17", done_cyc); else pass_cnt++;
    chk_cnt++;
    if (done_n !== 1) $display("FAIL save_done_count actual=%0d required=1", done_n); else pass_cnt++;
    chk_cnt++;
    if (first_busy !== 1 || last_busy !== 17 || busy_n !== 17)
      $display("FAIL save_busy_window actual=%0d..%0d(%0d) required=1..17(17)", first_busy, last_busy, busy_n);
    else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (wr_q.size() == 0) $display("FAIL save_write missing required=%h:%h", e.a, e.d);
      else begin
        o = wr_q.pop_front();
        if (o !== e) $display("FAIL save_write actual=%h:%h required=%h:%h", o.a, o.d, e.a, e.d);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_restore_latency();
    xfer_t e, o;
    clear_logs();
    ack_delay = 2;
    for (int i = 0; i < 8; i++) begin
      mem[16'h4000 + 16'(i)] = 16'hA000 + 16'(i);
      regs[i] <= 16'h0000;
      ld_exp_q.push_back({16'(i), 16'hA000 + 16'(i)});
    end
    start_op(1'b0, 1'b1, 16'h4000);
    run_watch(45);
    $display("txn restore base=4000 done_cyc=%0d loads=%0d", done_cyc, ld_q.size());
    chk_cnt++;
    if (ld_q.size() !== 8) $display("FAIL restore_ld_count actual=%0d required=8", ld_q.size()); else pass_cnt++;
    chk_cnt++;
    if (done_n !== 1 || err_n !== 0) $display("FAIL restore_done_err actual=%0d/%0d required=1/0", done_n, err_n); else pass_cnt++;
    chk_cnt++;
    if (done_cyc !== 33) $display("FAIL restore_done_cycle actual=%0d required=33", done_cyc); else pass_cnt++;
    while (ld_exp_q.size() > 0) begin
      e = ld_exp_q.pop_front();
      chk_cnt++;
      if (ld_q.size() == 0) $display("FAIL restore_load missing required=%0d:%h", e.a, e.d);
      else begin
        o = ld_q.pop_front();
        if (o !== e) $display("FAIL restore_load actual=%0d:%h required=%0d:%h", o.a, o.d, e.a, e.d);
        else pass_cnt++;
      end
    end
    for (int i = 0; i < 8; i++) begin
      chk_cnt++;
      if (regs[i] !== 16'hA000 + 16'(i)) $display("FAIL restore_reg%0d actual=%h required=%h", i, regs[i], 16'hA000 + 16'(i));
      else pass_cnt++;
    end
  endtask

  task automatic test_save_restore_priority();
    xfer_t e, o;
    clear_logs();
    ack_delay = 0;
    for (int i = 0; i < 8; i++) begin
      regs[i] <= 16'h5550 + 16'(i);
      exp_q.push_back({16'h3000 + 16'(i), 16'h5550 + 16'(i)});
    end
    start_op(1'b1, 1'b1, 16'h3000);
    run_watch(30);
    $display("txn save+restore base=3000 writes=%0d read_cycles=%0d", wr_q.size(), rd_req_cycles);
    chk_cnt++;
    if (rd_req_cycles !== 0) $display("FAIL prio_read_cycles actual=%0d required=0", rd_req_cycles); else pass_cnt++;
    chk_cnt++;
    if (ld_q.size() !== 0 || done_n !== 1) $display("FAIL prio_loads_done actual=%0d/%0d required=0/1", ld_q.size(), done_n); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (wr_q.size() == 0) $display("FAIL prio_write missing required=%h:%h", e.a, e.d);
      else begin
        o = wr_q.pop_front();
        if (o !== e) $display("FAIL prio_write actual=%h:%h required=%h:%h", o.a, o.d, e.a, e.d);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_addr_wrap();
    xfer_t e, o;
    logic [15:0] addrs [0:7] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001,
                                 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    clear_logs();
    ack_delay = 0;
    for (int i = 0; i < 8; i++) begin
      regs[i] <= 16'hC0C0 + 16'(i);
      exp_q.push_back({addrs[i], 16'hC0C0 + 16'(i)});
    end
    start_op(1'b1, 1'b0, 16'hFFFE);
    run_watch(30);
    $display("txn save base=fffe writes=%0d done=%0d", wr_q.size(), done_n);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (wr_q.size() == 0) $display("FAIL wrap_write missing required=%h:%h", e.a, e.d);
      else begin
        o = wr_q.pop_front();
        if (o !== e) $display("FAIL wrap_write actual=%h:%h required=%h:%h", o.a, o.d, e.a, e.d);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_timeout();
    xfer_t e, o;
    clear_logs();
    ack_delay = 0;
    hang_en   = 1'b1;
    hang_addr = 16'h5002;
    for (int i = 0; i < 8; i++) begin
      mem[16'h5000 + 16'(i)] = 16'hB000 + 16'(i);
      regs[i] <= 16'h7770 + 16'(i);
    end
    ld_exp_q.push_back({16'd0, 16'hB000});
    ld_exp_q.push_back({16'd1, 16'hB001});
    start_op(1'b0, 1'b1, 16'h5000);
    run_watch(30);
    hang_en = 1'b0;
    $display("txn restore-timeout base=5000 err_cyc=%0d loads=%0d", err_cyc, ld_q.size());
    chk_cnt++;
    if (err_n !== 1 || done_n !== 0) $display("FAIL timeout_err_done actual=%0d/%0d required=1/0", err_n, done_n); else pass_cnt++;
    chk_cnt++;
    if (err_cyc !== 9) $display("FAIL timeout_err_cycle actual=%0d required=9", err_cyc); else pass_cnt++;
    chk_cnt++;
    if (ld_q.size() !== 2) $display("FAIL timeout_ld_count actual=%0d required=2", ld_q.size()); else pass_cnt++;
    chk_cnt++;
    if (Busy !== 1'b0) $display("FAIL timeout_idle actual=%b required=0", Busy); else pass_cnt++;
    while (ld_exp_q.size() > 0) begin
      e = ld_exp_q.pop_front();
      chk_cnt++;
      if (ld_q.size() == 0) $display("FAIL timeout_load missing required=%0d:%h", e.a, e.d);
      else begin
        o = ld_q.pop_front();
        if (o !== e) $display("FAIL timeout_load actual=%0d:%h required=%0d:%h", o.a, o.d, e.a, e.d);
        else pass_cnt++;
      end
    end
    for (int i = 2; i < 8; i++) begin
      chk_cnt++;
      if (regs[i] !== 16'h7770 + 16'(i)) $display("FAIL timeout_reg%0d actual=%h required=%h", i, regs[i], 16'h7770 + 16'(i));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_restore();
    xfer_t e, o;
    logic        found;
    logic [59:0] outs;
    clear_logs();
    ack_delay = 0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem[16'h4000 + 16'(i)] = 16'hA000 + 16'(i);
      regs[i] <= 16'h1230 + 16'(i);
    end
    start_op(1'b0, 1'b1, 16'h4000);
    for (int c = 0; c < 40; c++) begin
      if (LD_REG_OUT && DR_SEL == 3'd3) begin
        found = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    chk_cnt++;
    if (!found) $display("FAIL midreset_reach_ld3 actual=0 required=1"); else pass_cnt++;
    Reset = 1'b1;
    #1;
    chk_cnt++;
    if ({LD_REG_OUT, MEM_REQ} !== 2'b00) $display("FAIL midreset_gating actual=%b required=00", {LD_REG_OUT, MEM_REQ}); else pass_cnt++;
    @(negedge Clk);
    Reset = 1'b0;
    outs = {Busy, Done, Error, MEM_REQ, MEM_WE, LD_REG_OUT, SR1_SEL, DR_SEL,
            REG_WDATA, MEM_ADDR, MEM_WDATA};
    $display("txn restore-reset base=4000 outs=%h r2=%h r3=%h", outs, regs[2], regs[3]);
    chk_cnt++;
    if (outs !== 60'd0) $display("FAIL midreset_outputs actual=%h required=0", outs); else pass_cnt++;
    chk_cnt++;
    if (regs[3] !== 16'h1233) $display("FAIL midreset_r3 actual=%h required=1233", regs[3]); else pass_cnt++;
    chk_cnt++;
    if (regs[2] !== 16'hA002) $display("FAIL midreset_r2 actual=%h required=a002", regs[2]); else pass_cnt++;

    clear_logs();
    for (int i = 0; i < 8; i++)
      exp_q.push_back({16'h6000 + 16'(i), (i < 3) ? 16'hA000 + 16'(i) : 16'h1230 + 16'(i)});
    start_op(1'b1, 1'b0, 16'h6000);
    run_watch(30);
    $display("txn save-after-reset base=6000 done_cyc=%0d writes=%0d", done_cyc, wr_q.size());
    chk_cnt++;
    if (done_cyc !== 17 || done_n !== 1) $display("FAIL postreset_done actual=%0d/%0d required=17/1", done_cyc, done_n); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (wr_q.size() == 0) $display("FAIL postreset_write missing required=%h:%h", e.a, e.d);
      else begin
        o = wr_q.pop_front();
        if (o !== e) $display("FAIL postreset_write actual=%h:%h required=%h:%h", o.a, o.d, e.a, e.d);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_save_basic();
    test_restore_latency();
    test_save_restore_priority();
    test_addr_wrap();
    test_timeout();
    test_reset_mid_restore();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/reg_context_seq.md
Name: reg_context_seq

Overview:
- Sequencer that saves the 8 LC-3 general registers to memory and restores them from memory, for context switch and trap entry.
- It is the initiator on the register file's ports: it drives the SR1 read select and captures the read data; it drives DR, LD_REG and the write data.
- On the other side it acts as a req/ack master toward the memory controller.

Parameters:
- NREGS, 8, number of registers transferred (indices 0..NREGS-1).
- ACK_TIMEOUT, 255, maximum cycles to wait for MEM_ACK before abort; 0 disables the timeout.

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- Save  in  1  start save; sampled in IDLE only
- Restore  in  1  start restore; sampled in IDLE only
- Base  in  16  memory base address; latched at start
- SR1_SEL  out  3  register file read select
- SR1_DATA  in  16  register file read data (combinational from SR1_SEL)
- DR_SEL  out  3  register file write select
- REG_WDATA  out  16  register file write data
- LD_REG_OUT  out  1  register file write enable
- MEM_REQ  out  1  memory request
- MEM_WE  out  1  1 = write, 0 = read
- MEM_ADDR  out  16  memory address
- MEM_WDATA  out  16  memory write data
- MEM_RDATA  in  16  memory read data, valid in the cycle MEM_ACK=1
- MEM_ACK  in  1  one-cycle completion strobe from memory
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse on successful completion
- Error  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: the FSM goes to IDLE; idx, hold, base_q and the timeout counter clear to 0.
- All outputs are 0 on reset. LD_REG_OUT and MEM_REQ are additionally gated combinationally with ~Reset, because the register file gives LD_REG priority over its own Reset.
- States:
  - IDLE
  - SV_RD
  - SV_MEM
  - RS_MEM
  - RS_LD
  - FIN
  - ABORT
- IDLE:
  - Save=1 → latch Base into base_q, idx=0, go to SV_RD.
  - Else Restore=1 → latch Base, idx=0, go to RS_MEM.
  - Save and Restore together → Save wins.
  - Save/Restore while Busy are ignored (not queued).
- SV_RD (1 cycle): SR1_SEL=idx; SR1_DATA is captured into hold at the clock edge; go to SV_MEM.
- SV_MEM:
  - Drives MEM_REQ=1, MEM_WE=1, MEM_ADDR=base_q+idx (mod 2^16), MEM_WDATA=hold.
  - All of these hold stable until MEM_ACK is sampled high.
  - On ACK: if idx==NREGS-1 go to FIN, else idx++ and go to SV_RD.
- RS_MEM:
  - Drives MEM_REQ=1, MEM_WE=0, MEM_ADDR=base_q+idx.
  - On ACK: capture MEM_RDATA into hold, go to RS_LD.
- RS_LD (1 cycle):
  - DR_SEL=idx, REG_WDATA=hold, LD_REG_OUT=1.
  - Then: if idx==NREGS-1 go to FIN, else idx++ and go to RS_MEM.
- FIN: Done=1 for 1 cycle, then IDLE.
- ABORT: Error=1 for 1 cycle, then IDLE; no further register or memory writes.
- Timeout:
  - The counter clears on entry to SV_MEM/RS_MEM and increments each cycle without ACK.
  - On reaching ACK_TIMEOUT (when non-zero) → ABORT.
  - Registers already restored keep their new values (partial restore is permitted and flagged by Error).
- MEM_ACK outside SV_MEM/RS_MEM is ignored.
- LD_REG_OUT is high only in RS_LD. MEM_REQ is high only in SV_MEM/RS_MEM.
- Latency with zero-wait memory (ACK in first REQ cycle):
  - Save = 2·NREGS cycles + FIN.
  - Restore = 2·NREGS cycles + FIN.
  - Busy rises the cycle after the start is sampled.
- Address wrap: with base_q=16'hFFFC, idx 4 addresses 16'h0000.
- Reset mid-operation: abort immediately, no Done/Error, no LD_REG pulse in the reset cycle; memory contents already written persist.
- Width rules: idx is $clog2(NREGS) bits; the address is base_q + zero-extended idx, truncated to 16 bits.

Decomposition:
- Package SLC3_2 gains:
  - the ctx_state_t enum (IDLE, SV_RD, SV_MEM, RS_MEM, RS_LD, FIN, ABORT)
  - the constant CTX_NREGS=8
- The timeout counter is a natural sub-module, ack_timer: inputs clr, en, limit; output expired.

Test Plan:
- Preload R0..R7=16'h1110+i, Base=16'h3000, ACK on the first REQ cycle, Save pulse → mem[3000..3007] = 1110..1117, Done at cycle 17, Busy cycles 1..17.
- mem[4000..4007]=16'hA000+i, 2-cycle ACK latency, Restore → R0..R7 = A000..A007, exactly 8 LD_REG pulses, Done once.
- Save and Restore asserted together with Base=16'h3000 → save sequence only; MEM_WE=1 on every request.
- Base=16'hFFFE, Save → addresses FFFE, FFFF, 0000..0005.
- ACK_TIMEOUT=4, no ACK for the 3rd restore read → R0, R1 loaded, Error pulse, R2..R7 unchanged, back to IDLE.
- Reset asserted in RS_LD of idx 3 → no write to R3, outputs 0 next cycle, a new Save then runs normally.
